// File: rtl/fetch_pkg.sv
// Shared types and constants for the milano instruction prefetch unit.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_STEP = 32'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign do_pop_s  = pop && !empty_s;
    assign do_push_s = push && (!full_s || do_pop_s);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = empty_s;
    assign full  = full_s;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Prefetch unit: issues sequential word fetches under a credit limit and
// buffers returned instructions with their PCs for the decode stage.
module fetch_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int INSTR_W   = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [ADDR_W-1:0]  boot_addr_i,
    input  logic               fetch_en_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_addr_i,
    output logic               req_o,
    output logic [ADDR_W-1:0]  addr_o,
    input  logic               gnt_i,
    input  logic               rvalid_i,
    input  logic [INSTR_W-1:0] rdata_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    input  logic               ready_i
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e     state_r, state_next_s;
    logic             booted_r, booted_next_s;
    logic             req_r, req_next_s;
    logic [ADDR_W-1:0] addr_r, addr_next_s;
    logic [ADDR_W-1:0] rsp_pc_r, rsp_pc_next_s;
    logic [OW-1:0]    outst_r, outst_next_s;
    logic [OW-1:0]    discard_r, discard_next_s;

    logic [ADDR_W-1:0] boot_aligned_s;
    logic [ADDR_W-1:0] redir_aligned_s;
    logic             grant_s;
    logic             push_s;
    logic             pop_s;
    logic             credit_ok_s;
    logic             start_s;
    logic [CW-1:0]    fifo_count_s;
    logic [CW-1:0]    fifo_cnt_next_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    fetch_entry_t     fifo_wdata_s;
    fetch_entry_t     fifo_head_s;
    logic             unused_addr_bits_s;

    assign boot_aligned_s     = {boot_addr_i[ADDR_W-1:2], 2'b00};
    assign redir_aligned_s    = {redirect_addr_i[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits_s = ^{boot_addr_i[1:0], redirect_addr_i[1:0]};

    assign grant_s = req_r && gnt_i;
    assign pop_s   = !fifo_empty_s && ready_i;
    // A response only lands when it is not stale; the credit check keeps a slot free.
    assign push_s  = rvalid_i && !redirect_i && (discard_r == {OW{1'b0}})
                     && (!fifo_full_s || pop_s);
    assign start_s = (state_r == IDLE) && fetch_en_i && !booted_r;

    assign fifo_wdata_s.pc    = rsp_pc_r;
    assign fifo_wdata_s.instr = rdata_i;

    // FSM next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = fetch_en_i ? RUN : IDLE;
            RUN:     state_next_s = fetch_en_i ? RUN : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Counters, addresses and request credit for the next cycle.
    always_comb begin
        outst_next_s    = outst_r + OW'(grant_s) - OW'(rvalid_i);
        discard_next_s  = discard_r;
        addr_next_s     = addr_r;
        rsp_pc_next_s   = rsp_pc_r;
        booted_next_s   = booted_r;
        fifo_cnt_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
        req_next_s      = 1'b0;

        if (redirect_i) begin
            discard_next_s  = outst_next_s;
            addr_next_s     = redir_aligned_s;
            rsp_pc_next_s   = redir_aligned_s;
            booted_next_s   = 1'b1;
            fifo_cnt_next_s = {CW{1'b0}};
        end else if (start_s) begin
            addr_next_s   = boot_aligned_s;
            rsp_pc_next_s = boot_aligned_s;
            booted_next_s = 1'b1;
        end else begin
            if (rvalid_i && (discard_r != {OW{1'b0}})) begin
                discard_next_s = discard_r - OW'(1);
            end else begin
                discard_next_s = discard_r;
            end
            addr_next_s   = grant_s ? addr_r + FETCH_STEP : addr_r;
            rsp_pc_next_s = push_s ? rsp_pc_r + FETCH_STEP : rsp_pc_r;
        end

        credit_ok_s = ((32'(fifo_cnt_next_s) + 32'(outst_next_s)) < 32'(DEPTH))
                      && (32'(outst_next_s) < 32'(MAX_OUTST));

        // A pending ungranted request must stay stable unless redirected.
        if (!redirect_i && req_r && !gnt_i) begin
            req_next_s = 1'b1;
        end else begin
            req_next_s = (state_next_s == RUN) && credit_ok_s;
        end
    end

    // State and control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            booted_r  <= 1'b0;
            req_r     <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            rsp_pc_r  <= {ADDR_W{1'b0}};
            outst_r   <= {OW{1'b0}};
            discard_r <= {OW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            booted_r  <= booted_next_s;
            req_r     <= req_next_s;
            addr_r    <= addr_next_s;
            rsp_pc_r  <= rsp_pc_next_s;
            outst_r   <= outst_next_s;
            discard_r <= discard_next_s;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_s),
        .wdata  (fifo_wdata_s),
        .pop    (pop_s),
        .flush  (redirect_i),
        .rdata  (fifo_head_s),
        .count  (fifo_count_s),
        .empty  (fifo_empty_s),
        .full   (fifo_full_s)
    );

    // Until the first fetch the address register is unused, so show the boot address.
    assign req_o   = req_r;
    assign addr_o  = booted_r ? addr_r : boot_aligned_s;
    assign valid_o = !fifo_empty_s;
    assign instr_o = fifo_head_s.instr;
    assign pc_o    = fifo_head_s.pc;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed, table-driven bench for fetch_prefetch_buffer with an in-order memory model.
module tb_fetch_prefetch_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] boot_addr_i;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        req_o;
    logic [31:0] addr_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        ready_i;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rsp_q [$];

    typedef struct {
        logic        fe, gnt, rdy, redir;
        logic [31:0] raddr;
        logic        hold;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [36];
    vec_t post [4];

    always #5 clk_i = ~clk_i;

    fetch_prefetch_buffer dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .boot_addr_i     (boot_addr_i),
        .fetch_en_i      (fetch_en_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .req_o           (req_o),
        .addr_o          (addr_o),
        .gnt_i           (gnt_i),
        .rvalid_i        (rvalid_i),
        .rdata_i         (rdata_i),
        .valid_o         (valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .ready_i         (ready_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    function automatic vec_t mk(input logic fe, input logic g, input logic r, input logic rd,
                                input logic [31:0] ra, input logic h, input logic eq,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.fe = fe; v.gnt = g; v.rdy = r; v.redir = rd; v.raddr = ra; v.hold = h;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and play the memory: respond one cycle after a grant.
    task automatic drive(input vec_t v);
        logic [31:0] a;
        fetch_en_i      = v.fe;
        gnt_i           = v.gnt;
        ready_i         = v.rdy;
        redirect_i      = v.redir;
        redirect_addr_i = v.raddr;
        rvalid_i        = 1'b0;
        rdata_i         = 32'h0;
        if (!v.hold && rsp_q.size() > 0) begin
            a        = rsp_q.pop_front();
            rvalid_i = 1'b1;
            rdata_i  = mem_word(a);
        end
        if (req_o && gnt_i) rsp_q.push_back(addr_o);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        chk({tag, ".req"},   {31'd0, req_o},   {31'd0, v.e_req});
        chk({tag, ".addr"},  addr_o,           v.e_addr);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v.e_valid});
        chk({tag, ".fifo_bound"}, {31'd0, (32'(dut.fifo_count_s) <= 32'd4)}, 32'd1);
        if (v.e_valid) begin
            chk({tag, ".pc"},    pc_o,    v.e_pc);
            chk({tag, ".instr"}, instr_o, mem_word(v.e_pc));
        end
        drive(v);
        @(negedge clk_i);
    endtask

    initial begin
        // boot, backpressure, grant stall
        vecs[0]  = mk(1,1,1,0,32'h0,0, 0,32'h8000_0000,0,32'h0);
        vecs[1]  = mk(1,1,1,0,32'h0,0, 1,32'h8000_0000,0,32'h0);
        vecs[2]  = mk(1,1,1,0,32'h0,0, 1,32'h8000_0004,0,32'h0);
        vecs[3]  = mk(1,1,0,0,32'h0,0, 1,32'h8000_0008,1,32'h8000_0000);
        vecs[4]  = mk(1,1,0,0,32'h0,0, 1,32'h8000_000C,1,32'h8000_0000);
        vecs[5]  = mk(1,1,0,0,32'h0,0, 0,32'h8000_0010,1,32'h8000_0000);
        vecs[6]  = mk(1,1,0,0,32'h0,0, 0,32'h8000_0010,1,32'h8000_0000);
        vecs[7]  = mk(1,1,1,0,32'h0,0, 0,32'h8000_0010,1,32'h8000_0000);
        for (int i = 8; i <= 12; i++)
            vecs[i] = mk(1,0,0,0,32'h0,0, 1,32'h8000_0010,1,32'h8000_0004);
        vecs[13] = mk(1,1,0,0,32'h0,0, 1,32'h8000_0010,1,32'h8000_0004);
        vecs[14] = mk(1,1,0,0,32'h0,0, 0,32'h8000_0014,1,32'h8000_0004);
        vecs[15] = mk(1,1,1,0,32'h0,0, 0,32'h8000_0014,1,32'h8000_0004);
        // redirect with 2 outstanding and 1 buffered entry
        vecs[16] = mk(1,1,1,0,32'h0,1, 1,32'h8000_0014,1,32'h8000_0008);
        vecs[17] = mk(1,1,1,0,32'h0,1, 1,32'h8000_0018,1,32'h8000_000C);
        vecs[18] = mk(1,1,0,1,32'h0000_0103,1, 0,32'h8000_001C,1,32'h8000_0010);
        vecs[19] = mk(1,1,1,0,32'h0,0, 0,32'h0000_0100,0,32'h0);
        vecs[20] = mk(1,1,1,0,32'h0,0, 1,32'h0000_0100,0,32'h0);
        vecs[21] = mk(1,1,1,0,32'h0,0, 1,32'h0000_0104,0,32'h0);
        vecs[22] = mk(1,1,1,0,32'h0,0, 1,32'h0000_0108,1,32'h0000_0100);
        // wrap, with a stale grant in the redirect cycle
        vecs[23] = mk(1,1,1,1,32'hFFFF_FFFC,0, 1,32'h0000_010C,1,32'h0000_0104);
        vecs[24] = mk(1,1,1,0,32'h0,0, 1,32'hFFFF_FFFC,0,32'h0);
        vecs[25] = mk(1,1,1,0,32'h0,0, 1,32'h0000_0000,0,32'h0);
        vecs[26] = mk(1,1,1,0,32'h0,0, 1,32'h0000_0004,1,32'hFFFF_FFFC);
        // disable with 2 outstanding, drain, re-enable
        vecs[27] = mk(1,1,1,0,32'h0,1, 1,32'h0000_0008,1,32'h0000_0000);
        vecs[28] = mk(0,1,0,0,32'h0,0, 0,32'h0000_000C,0,32'h0);
        vecs[29] = mk(0,1,0,0,32'h0,0, 0,32'h0000_000C,1,32'h0000_0004);
        vecs[30] = mk(0,1,1,0,32'h0,0, 0,32'h0000_000C,1,32'h0000_0004);
        vecs[31] = mk(0,1,1,0,32'h0,0, 0,32'h0000_000C,1,32'h0000_0008);
        vecs[32] = mk(1,1,1,0,32'h0,0, 0,32'h0000_000C,0,32'h0);
        vecs[33] = mk(1,1,1,0,32'h0,0, 1,32'h0000_000C,0,32'h0);
        vecs[34] = mk(1,1,1,0,32'h0,0, 1,32'h0000_0010,0,32'h0);
        vecs[35] = mk(1,1,1,0,32'h0,0, 1,32'h0000_0014,1,32'h0000_000C);
        // fresh boot after a mid-run reset
        post[0]  = mk(1,1,1,0,32'h0,0, 0,32'h0000_1004,0,32'h0);
        post[1]  = mk(1,1,1,0,32'h0,0, 1,32'h0000_1004,0,32'h0);
        post[2]  = mk(1,1,1,0,32'h0,0, 1,32'h0000_1008,0,32'h0);
        post[3]  = mk(1,1,1,0,32'h0,0, 1,32'h0000_100C,1,32'h0000_1004);

        rst_ni          = 1'b0;
        boot_addr_i     = 32'h8000_0002;
        fetch_en_i      = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = 32'h0;
        gnt_i           = 1'b0;
        rvalid_i        = 1'b0;
        rdata_i         = 32'h0;
        ready_i         = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst.req",   {31'd0, req_o},   32'd0);
        chk("rst.addr",  addr_o,           32'h8000_0000);
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.instr", instr_o,          32'h0);
        chk("rst.pc",    pc_o,             32'h0);
        rst_ni = 1'b1;

        for (int i = 0; i < 36; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // keep traffic going, then hit reset in the middle of a cycle
        for (int i = 0; i < 3; i++) begin
            drive(mk(1,1,1,0,32'h0,0, 0,32'h0,0,32'h0));
            @(negedge clk_i);
        end
        boot_addr_i = 32'h0000_1007;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst.req",   {31'd0, req_o},   32'd0);
        chk("arst.addr",  addr_o,           32'h0000_1004);
        chk("arst.valid", {31'd0, valid_o}, 32'd0);
        chk("arst.instr", instr_o,          32'h0);
        chk("arst.pc",    pc_o,             32'h0);
        fetch_en_i = 1'b0;
        gnt_i      = 1'b0;
        ready_i    = 1'b0;
        rvalid_i   = 1'b0;
        rsp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) run_vec($sformatf("p%0d", i), post[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
Parametrised instruction prefetch unit for the milano core front end, placed between boot/PC-redirect control and instruction memory. It issues sequential word-aligned fetch requests over a request/grant/rvalid memory handshake, keeps up to MAX_OUTST requests in flight and buffers returned instructions, with their PCs, in a DEPTH-entry FIFO. The decode stage consumes instructions through a valid/ready handshake. Branch/jump redirects flush the buffer and discard stale responses.

Parameters:
ADDR_W, 32, fetch address / PC width
INSTR_W, 32, instruction data width
DEPTH, 4, FIFO entries (power of 2, >=2)
MAX_OUTST, 2, maximum granted but unanswered requests (1..DEPTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
boot_addr_i  in  ADDR_W  first fetch address after reset; bits[1:0] ignored
fetch_en_i  in  1  permits new requests
redirect_i  in  1  flush and restart at redirect_addr_i
redirect_addr_i  in  ADDR_W  new PC; bits[1:0] forced to 0
req_o  out  1  memory request
addr_o  out  ADDR_W  request address
gnt_i  in  1  request accepted this cycle
rvalid_i  in  1  response valid (in order, >=1 cycle after its grant)
rdata_i  in  INSTR_W  response data
valid_o  out  1  FIFO head valid
instr_o  out  INSTR_W  head instruction
pc_o  out  ADDR_W  head PC
ready_i  in  1  consumer accepts head

Behaviour:
- Reset values: req_o=0, addr_o={boot_addr_i[ADDR_W-1:2],2'b00}, valid_o=0, instr_o=0, pc_o=0; FIFO empty, outstanding=0, discard=0, state IDLE.
- States: IDLE, RUN. IDLE->RUN when fetch_en_i=1; RUN->IDLE when fetch_en_i=0. Leaving IDLE for the first time after reset fetches from boot_addr_i; later re-entry continues from the current addr_o.
- req_o=1 only in RUN and when fifo_count + outstanding < DEPTH and outstanding < MAX_OUTST. Registered, so fetch_en_i rising in cycle 0 gives req_o in cycle 1 with addr_o=boot address.
- Handshake: req_o&gnt_i accepts a request; outstanding +1 and addr_o += 4 next cycle (mod 2^ADDR_W, wraps 0xFFFF_FFFC->0). While req_o=1 and gnt_i=0, req_o and addr_o hold stable. Only a redirect may change them.
- Response: rvalid_i with discard=0 writes {rsp_pc,rdata_i} to the FIFO; rsp_pc += 4; outstanding -1. With discard>0 the data is dropped; discard -1 and outstanding -1.
- Output: valid_o = FIFO not empty. instr_o/pc_o come from the head. valid_o&ready_i pops the head. Best latency: grant in cycle 1, rvalid in cycle 2, valid_o in cycle 3.
- Redirect (highest priority): same cycle, any valid_o&ready_i pop completes. Next cycle: FIFO empty, addr_o=rsp_pc=redirect_addr, discard=outstanding after this cycle's grant/rvalid updates. A grant in the redirect cycle counts as stale. An rvalid_i in the redirect cycle is dropped. req_o is re-evaluated with the new address in the next cycle.
- Simultaneous rvalid write and pop with a full FIFO is legal, because the credit check guarantees a free slot. Overflow and underflow are impossible; the bench asserts this.
- fetch_en_i=0 stops only new requests. In-flight responses still fill the FIFO and the consumer can drain it.
- rst_ni assertion mid-operation clears all state immediately. In-flight memory responses after reset are the memory's responsibility.
- outstanding and discard are $clog2(MAX_OUTST+1) bits wide.

Decomposition:
- Package fetch_pkg: fetch_state_e (IDLE, RUN), fetch_entry_t struct {pc, instr} sized from package constants FETCH_ADDR_W and FETCH_INSTR_W, and the PC increment constant FETCH_STEP=4.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, empty and full. The top level holds the FSM, the credit/outstanding/discard counters and the address registers.

Test Plan:
- Boot: boot_addr_i=0x8000_0002, fetch_en_i=1, gnt_i=1, rvalid 1 cycle after grant, ready_i=1 -> addr_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008. valid_o first high in cycle 3 with pc_o=0x8000_0000.
- Backpressure: ready_i=0, DEPTH=4 -> exactly 4 grants, then req_o=0. FIFO holds PCs 0x8000_0000..0x8000_000C. No overflow. One pop causes req_o to rise again.
- Grant stall: gnt_i=0 for 5 cycles -> req_o=1 and addr_o constant for all 5. Grant on cycle 6 -> addr_o advances by 4.
- Redirect: 2 outstanding and 1 FIFO entry, redirect_i with redirect_addr_i=0x0000_0103 -> FIFO empty next cycle and both stale responses dropped. First valid_o shows pc_o=0x0000_0100.
- Wrap: redirect to 0xFFFF_FFFC -> following requests 0xFFFF_FFFC, 0x0000_0000. pc_o matches.
- Disable: fetch_en_i=0 with 2 outstanding -> no new req_o. Both responses enter the FIFO and drain. Re-enable -> fetch resumes at the next sequential address.
